// File: rtl/tfmbs_pkg.sv
// rtl/tfmbs_pkg.sv - shared trit encodings, kernel codes and streamer FSM states
package tfmbs_pkg;

    localparam int TRITS_PER_WORD = 16;
    localparam int TRIT_W         = 2;
    localparam int WORD_W         = TRITS_PER_WORD * TRIT_W;
    localparam int IDX_W          = $clog2(TRITS_PER_WORD);

    // Kernel codes understood by the lane ALU
    localparam logic [2:0] OP_DOT = 3'h1;
    localparam logic [2:0] OP_MUL = 3'h3;

    // Balanced-ternary trit encodings
    localparam logic [1:0] TRIT_ZERO = 2'b00;
    localparam logic [1:0] TRIT_POS  = 2'b01;
    localparam logic [1:0] TRIT_NEG  = 2'b10;
    localparam logic [1:0] TRIT_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic trit_is_illegal(input logic [1:0] t);
        return (t == TRIT_ILL);
    endfunction

    // Illegal codes are replaced by zero so the ALU never sees 2'b11
    function automatic logic [1:0] sanitize_trit(input logic [1:0] t);
        return trit_is_illegal(t) ? TRIT_ZERO : t;
    endfunction

endpackage

// File: rtl/tfmbs_trit_shift.sv
// rtl/tfmbs_trit_shift.sv - paired 16-trit shift register with illegal-code sanitising
module tfmbs_trit_shift
    import tfmbs_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic              present,
    input  logic [WORD_W-1:0] in_weight_word,
    input  logic [WORD_W-1:0] in_trit_word,
    output logic [1:0]        weight,
    output logic [1:0]        trit_in,
    output logic              illegal
);

    logic [WORD_W-1:0] weight_sr;
    logic [WORD_W-1:0] trit_sr;
    logic [1:0]        weight_raw;
    logic [1:0]        trit_raw;

    assign weight_raw = weight_sr[1:0];
    assign trit_raw   = trit_sr[1:0];

    // Load wins over shift so a back-to-back reload at trit 15 starts cleanly at trit 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weight_sr <= '0;
            trit_sr   <= '0;
        end else if (load) begin
            weight_sr <= in_weight_word;
            trit_sr   <= in_trit_word;
        end else if (shift) begin
            weight_sr <= {TRIT_ZERO, weight_sr[WORD_W-1:TRIT_W]};
            trit_sr   <= {TRIT_ZERO, trit_sr[WORD_W-1:TRIT_W]};
        end
    end

    // Present the current trit pair only while the lane is enabled; zero otherwise
    always_comb begin
        weight  = TRIT_ZERO;
        trit_in = TRIT_ZERO;
        illegal = 1'b0;
        if (present) begin
            weight  = sanitize_trit(weight_raw);
            trit_in = sanitize_trit(trit_raw);
            illegal = trit_is_illegal(weight_raw) | trit_is_illegal(trit_raw);
        end
    end

endmodule

// File: rtl/ternary_trit_streamer.sv
// rtl/ternary_trit_streamer.sv - streams packed trit word pairs to a lane ALU one trit per cycle
module ternary_trit_streamer
    import tfmbs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] length,
    input  logic [2:0]       op_mode_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_weight_word,
    input  logic [31:0]      in_trit_word,
    output logic [1:0]       weight,
    output logic [1:0]       trit_in,
    output logic [2:0]       op_mode,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             enc_err
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic [IDX_W-1:0] idx;
    logic             zero_done;
    logic             in_shift;
    logic             last_trit;
    logic             word_end;
    logic             more_after;
    logic             handshake;
    logic             start_job;
    logic             start_zero;
    logic             illegal;

    assign in_shift   = (state == ST_SHIFT);
    assign last_trit  = (remaining == CNT_W'(1));
    assign more_after = (remaining > CNT_W'(1));
    assign word_end   = (idx == IDX_W'(TRITS_PER_WORD - 1));
    assign start_job  = (state == ST_IDLE) & start & (length != '0);
    assign start_zero = (state == ST_IDLE) & start & (length == '0);

    // A new word pair is wanted while waiting in LOAD, or on the last trit of a word
    // that still has trits to follow, which lets the reload happen without a bubble
    assign in_ready  = (state == ST_LOAD) | (in_shift & word_end & more_after);
    assign handshake = in_valid & in_ready;

    assign enable = in_shift;
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_DONE) | zero_done;

    tfmbs_trit_shift u_shift (
        .clk            (clk),
        .reset          (reset),
        .load           (handshake),
        .shift          (in_shift),
        .present        (in_shift),
        .in_weight_word (in_weight_word),
        .in_trit_word   (in_trit_word),
        .weight         (weight),
        .trit_in        (trit_in),
        .illegal        (illegal)
    );

    // Next-state decode for the job FSM
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_job) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (handshake) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_trit) begin
                    state_next = ST_DONE;
                end else if (word_end && !handshake) begin
                    state_next = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remaining trit pairs in the job; counts down once per enabled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
        end else if (start_job) begin
            remaining <= length;
        end else if (in_shift) begin
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Trit index within the current word; restarts at 0 on every word capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (start_job || handshake) begin
            idx <= '0;
        end else if (in_shift) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Kernel code held for the whole job and beyond, until the next accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_mode <= '0;
        end else if (start_job) begin
            op_mode <= op_mode_in;
        end
    end

    // Sticky encoding error, cleared only by a new job
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_err <= 1'b0;
        end else if (start_job) begin
            enc_err <= 1'b0;
        end else if (illegal) begin
            enc_err <= 1'b1;
        end
    end

    // Zero-length job completes immediately without leaving IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_done <= 1'b0;
        end else begin
            zero_done <= start_zero;
        end
    end

endmodule

// File: doc/ternary_trit_streamer.md
TERNARY_TRIT_STREAMER -- requirements
Module: ternary_trit_streamer

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the trit-count register and the length input.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: one-cycle job request, sampled only in IDLE.
REQ-005 SHALL have port length, input, CNT_W bits: number of trit pairs in the job, latched on accepted start.
REQ-006 SHALL have port op_mode_in, input, 3 bits: kernel code, latched on accepted start.
REQ-007 SHALL have port in_valid, input, 1 bit: packed word pair available.
REQ-008 SHALL have port in_ready, output, 1 bit: block accepts the word pair this cycle.
REQ-009 SHALL have port in_weight_word, input, 32 bits: 16 packed 2-bit weight trits, trit 0 at bits [1:0].
REQ-010 SHALL have port in_trit_word, input, 32 bits: 16 packed 2-bit input trits, same layout as in_weight_word.
REQ-011 SHALL have port weight, output, 2 bits: registered weight trit to the lane ALU.
REQ-012 SHALL have port trit_in, output, 2 bits: registered input trit to the lane ALU.
REQ-013 SHALL have port op_mode, output, 3 bits: latched kernel code.
REQ-014 SHALL have port enable, output, 1 bit: weight and trit_in are valid this cycle.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-017 SHALL have port enc_err, output, 1 bit: sticky flag set when the illegal code 2'b11 is seen.

Function
REQ-018 SHALL use 2-bit trit encoding 00 = 0, 01 = +1, 10 = -1; 11 is illegal.
REQ-019 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE.
REQ-020 IDLE: start with length != 0 SHALL latch length and op_mode_in, clear enc_err, then go to LOAD.
REQ-021 IDLE: start with length == 0 SHALL pulse done on the next cycle with no enable, and remain in IDLE.
REQ-022 start outside IDLE SHALL be ignored.
REQ-023 LOAD: in_ready SHALL be 1; handshake (in_valid & in_ready) SHALL capture both words into the shift registers and go to SHIFT.
REQ-024 SHIFT: the block SHALL assert enable every cycle, present trit index i (i = 0..15, LSB first), decrement the remaining count, and increment i.
REQ-025 SHIFT: in_ready SHALL be 1 only at i = 15 with remaining > 1; a handshake then SHALL reload the shift registers so the next cycle stays in SHIFT at i = 0 with no bubble.
REQ-026 SHIFT: at i = 15 with remaining > 1 and no handshake, the block SHALL go to LOAD, and enable SHALL be 0 until a word pair is accepted.
REQ-027 SHIFT: when remaining reaches 0, the block SHALL go to DONE, discarding unused trits of the word.
REQ-028 DONE: done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-029 Latency: the first enable SHALL occur in the cycle after the LOAD handshake.
REQ-030 Total enable cycles per job SHALL equal length exactly.
REQ-031 An illegal code on either trit SHALL be output as 00 with enable still 1, and SHALL set enc_err.
REQ-032 enc_err SHALL stay set until the next accepted start or reset.
REQ-033 weight and trit_in SHALL be 00 whenever enable = 0.
REQ-034 op_mode SHALL hold its latched value until the next accepted start.

Reset
REQ-035 Reset assertion SHALL immediately force IDLE; all outputs SHALL be 0, with in_ready = 0, enc_err = 0 and op_mode = 0.
REQ-036 Reset mid-job SHALL abandon the job with no done pulse, and the in-flight word SHALL be lost.

Structure
REQ-037 Kernel codes (DOT = 3'h1, MUL = 3'h3), trit encodings, TRITS_PER_WORD = 16 and the FSM state enum SHALL live in shared package tfmbs_pkg.
REQ-038 The 16-trit paired shift register with illegal-code sanitising SHALL be sub-module tfmbs_trit_shift; the FSM and counters SHALL stay in the top level.

Verification
REQ-039 Scenario: start, length = 5, op_mode_in = 1, word trits 0..4 = +1/+1 -> enable high for 5 consecutive cycles starting the cycle after the handshake, weight = trit_in = 01, done one cycle after the last enable.
REQ-040 Scenario: length = 32, in_valid held high -> 32 consecutive enable cycles with no bubble, exactly 2 handshakes.
REQ-041 Scenario: length = 20, in_valid low for 3 cycles after the first word -> enable gap of 3+ cycles after trit 15, remaining 4 trits delivered, 20 enables in total.
REQ-042 Scenario: length = 0 -> done pulse the next cycle, no enable, in_ready stays 0.
REQ-043 Scenario: word with trit 2 = 2'b11 -> output 00 at that enable, enc_err = 1 until the next start.
REQ-044 Scenario: reset asserted at trit 7 of a 16-trit job -> all outputs 0 at once, no done; a new job then runs correctly.
